// File: rtl/pu_riscv_if_queue.sv
// Instruction-fetch parcel queue and aligner: buffers bus parcels as halfwords and
// extracts 32-bit / RVC instructions (including parcel-straddling ones) with fault tags.
module pu_riscv_if_queue #(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     ILEN        = 32,
    parameter int unsigned     PARCEL_SIZE = 32,
    parameter int unsigned     DEPTH       = 8,
    parameter bit              HAS_RVC     = 1'b1,
    parameter logic [XLEN-1:0] PC_INIT     = 'h200
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           flush,
    input  logic [XLEN-1:0]                flush_pc,
    input  logic [PARCEL_SIZE-1:0]         parcel,
    input  logic [XLEN-1:0]                parcel_pc,
    input  logic                           parcel_valid,
    input  logic                           parcel_misaligned,
    input  logic                           parcel_page_fault,
    output logic                           parcel_ready,
    input  logic                           id_stall,
    output logic [ILEN-1:0]                if_instr,
    output logic [XLEN-1:0]                if_pc,
    output logic                           if_valid,
    output logic                           if_rvc,
    output logic                           if_misaligned,
    output logic                           if_page_fault,
    output logic [$clog2(DEPTH+1)-1:0]     if_occupancy
);

    localparam int unsigned HW = PARCEL_SIZE / 16;          // halfwords per parcel
    localparam int unsigned PB = $clog2(PARCEL_SIZE / 8);   // byte-offset bits in a parcel
    localparam int unsigned SW = PB - 1;                    // halfword-offset bits in a parcel
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

    // Queue storage
    logic [15:0]     data_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [DEPTH-1:0] mis_q;
    logic [DEPTH-1:0] pf_q;

    // Control state
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] exp_pc_q, exp_pc_d;

    // Push side
    logic            pc_match;
    logic            push;
    logic [SW-1:0]   skip;
    logic [CW-1:0]   push_n;
    logic [HW-1:0]   wr_en;
    logic [PW-1:0]   wr_idx [HW];
    logic [XLEN-1:0] wr_pc  [HW];

    // Head decode
    logic [PW-1:0]   rd_nxt;
    logic [15:0]     head_data;
    logic [15:0]     next_data;
    logic            head_fault;
    logic            is_short;
    logic [CW-1:0]   need;
    logic [CW-1:0]   pop_n;

    assign parcel_ready = (CW'(DEPTH) - count_q) >= CW'(HW);
    assign pc_match     = parcel_pc[XLEN-1:PB] == exp_pc_q[XLEN-1:PB];
    assign push         = parcel_valid && parcel_ready && !flush && pc_match;
    assign skip         = exp_pc_q[PB-1:1];

    always_comb begin
        push_n = '0;
        if (push) begin
            push_n = CW'(HW) - CW'(skip);
        end
        for (int i = 0; i < HW; i++) begin
            wr_en[i]  = push && (i >= int'(skip));
            wr_idx[i] = wr_ptr_q + PW'(i) - PW'(skip);
            wr_pc[i]  = {exp_pc_q[XLEN-1:PB], SW'(i), 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < HW; i++) begin
            if (wr_en[i]) begin
                data_q[wr_idx[i]] <= parcel[16*i +: 16];
                pc_q[wr_idx[i]]   <= wr_pc[i];
                mis_q[wr_idx[i]]  <= parcel_misaligned;
                pf_q[wr_idx[i]]   <= parcel_page_fault;
            end
        end
    end

    // A faulting head halfword goes out alone so a missing upper half cannot stall fetch.
    always_comb begin
        rd_nxt     = rd_ptr_q + PW'(1);
        head_data  = data_q[rd_ptr_q];
        next_data  = data_q[rd_nxt];
        head_fault = mis_q[rd_ptr_q] | pf_q[rd_ptr_q];
        is_short   = head_fault || (HAS_RVC && (head_data[1:0] != 2'b11));
        need       = is_short ? CW'(1) : CW'(2);
        if_valid   = count_q >= need;

        if_instr      = NOP;
        if_rvc        = 1'b0;
        if_misaligned = 1'b0;
        if_page_fault = 1'b0;
        if (if_valid) begin
            if_instr      = is_short ? ILEN'({16'h0000, head_data})
                                     : ILEN'({next_data, head_data});
            if_rvc        = is_short && !head_fault;
            if_misaligned = mis_q[rd_ptr_q] | (!is_short & mis_q[rd_nxt]);
            if_page_fault = pf_q[rd_ptr_q] | (!is_short & pf_q[rd_nxt]);
        end

        // Empty queue reports the next expected fetch PC.
        if_pc = (count_q == '0) ? exp_pc_q : pc_q[rd_ptr_q];

        pop_n = '0;
        if (if_valid && !id_stall) begin
            pop_n = need;
        end
    end

    assign if_occupancy = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        exp_pc_d = exp_pc_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            exp_pc_d = flush_pc;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop_n);
            wr_ptr_d = wr_ptr_q + PW'(push_n);
            count_d  = count_q + push_n - pop_n;
            if (push) begin
                exp_pc_d = {exp_pc_q[XLEN-1:PB] + (XLEN - PB)'(1), {PB{1'b0}}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            exp_pc_q <= PC_INIT;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            exp_pc_q <= exp_pc_d;
        end
    end

endmodule

// File: tb/tb_pu_riscv_if_queue.sv
// Directed, table-driven bench for pu_riscv_if_queue (XLEN=64, 32-bit parcels, DEPTH=8).
module tb_pu_riscv_if_queue;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic [63:0] flush_pc;
    logic [31:0] parcel;
    logic [63:0] parcel_pc;
    logic        parcel_valid;
    logic        parcel_misaligned;
    logic        parcel_page_fault;
    logic        parcel_ready;
    logic        id_stall;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        if_valid;
    logic        if_rvc;
    logic        if_misaligned;
    logic        if_page_fault;
    logic [3:0]  if_occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    pu_riscv_if_queue #(
        .XLEN        (64),
        .ILEN        (32),
        .PARCEL_SIZE (32),
        .DEPTH       (8),
        .HAS_RVC     (1'b1),
        .PC_INIT     (64'h200)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .parcel            (parcel),
        .parcel_pc         (parcel_pc),
        .parcel_valid      (parcel_valid),
        .parcel_misaligned (parcel_misaligned),
        .parcel_page_fault (parcel_page_fault),
        .parcel_ready      (parcel_ready),
        .id_stall          (id_stall),
        .if_instr          (if_instr),
        .if_pc             (if_pc),
        .if_valid          (if_valid),
        .if_rvc            (if_rvc),
        .if_misaligned     (if_misaligned),
        .if_page_fault     (if_page_fault),
        .if_occupancy      (if_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        flush;
        logic [63:0] flush_pc;
        logic [31:0] parcel;
        logic [63:0] ppc;
        logic        pv;
        logic        stall;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic        chk_pc;
        logic        e_rvc;
        logic [3:0]  e_occ;
        logic        e_ready;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic f, input logic [63:0] fpc, input logic [31:0] p,
                       input logic [63:0] ppc, input logic pv, input logic st,
                       input logic ev, input logic [31:0] ei, input logic [63:0] epc,
                       input logic cpc, input logic erv, input logic [3:0] eocc,
                       input logic erdy);
        vec_t v;
        v.flush = f;   v.flush_pc = fpc; v.parcel = p;   v.ppc = ppc;
        v.pv = pv;     v.stall = st;     v.e_valid = ev; v.e_instr = ei;
        v.e_pc = epc;  v.chk_pc = cpc;   v.e_rvc = erv;  v.e_occ = eocc;
        v.e_ready = erdy;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; flush_pc = '0; parcel = '0; parcel_pc = '0;
        parcel_valid = 1'b0; parcel_misaligned = 1'b0; parcel_page_fault = 1'b0;
    endtask

    task automatic push_parcel(input logic [31:0] p, input logic [63:0] pc,
                               input logic mis, input logic pf);
        parcel = p; parcel_pc = pc; parcel_valid = 1'b1;
        parcel_misaligned = mis; parcel_page_fault = pf;
        step();
        idle_inputs();
    endtask

    initial begin
        logic [63:0] base;
        logic [31:0] ins;

        // Reset held for two cycles with a parcel offered
        rstn = 1'b0; id_stall = 1'b0; idle_inputs();
        parcel = 32'h00a00093; parcel_pc = 64'h200; parcel_valid = 1'b1;
        step(); step();
        check("rst_valid", if_valid, 0);
        check("rst_instr", if_instr, 32'h13);
        check("rst_ready", parcel_ready, 1);
        check("rst_occ", if_occupancy, 0);
        check("rst_pc", if_pc, 64'h200);
        check("rst_rvc", if_rvc, 0);
        check("rst_pf", if_page_fault, 0);
        rstn = 1'b1; idle_inputs();

        //  flush fpc     parcel        ppc      pv st  v  instr         pc      cpc rvc occ rdy
        add(0, 64'h0,   32'h00a00093, 64'h200, 1, 0, 1, 32'h00a00093, 64'h200, 1, 0, 2, 1);
        add(0, 64'h0,   32'h00b00113, 64'h204, 1, 0, 1, 32'h00b00113, 64'h204, 1, 0, 2, 1);
        add(0, 64'h0,   32'h0,        64'h0,   0, 0, 0, 32'h13,       64'h0,   0, 0, 0, 1);
        add(1, 64'h200, 32'h0,        64'h0,   0, 0, 0, 32'h13,       64'h0,   0, 0, 0, 1);
        add(0, 64'h0,   32'h00934501, 64'h200, 1, 0, 1, 32'h00004501, 64'h200, 1, 1, 2, 1);
        add(0, 64'h0,   32'h0,        64'h0,   0, 0, 0, 32'h13,       64'h0,   0, 0, 1, 1);
        add(0, 64'h0,   32'h000000a0, 64'h204, 1, 0, 1, 32'h00a00093, 64'h202, 1, 0, 3, 1);
        add(0, 64'h0,   32'h0,        64'h0,   0, 0, 1, 32'h00000000, 64'h206, 1, 1, 1, 1);
        add(1, 64'h206, 32'h0,        64'h0,   0, 0, 0, 32'h13,       64'h0,   0, 0, 0, 1);
        add(0, 64'h0,   32'hdeadbeef, 64'h200, 1, 0, 0, 32'h13,       64'h0,   0, 0, 0, 1);
        add(0, 64'h0,   32'h00134501, 64'h204, 1, 0, 0, 32'h13,       64'h206, 1, 0, 1, 1);
        add(0, 64'h0,   32'h000100a0, 64'h208, 1, 0, 1, 32'h00a00013, 64'h206, 1, 0, 3, 1);
        add(0, 64'h0,   32'h0,        64'h0,   0, 0, 1, 32'h00000001, 64'h20a, 1, 1, 1, 1);
        add(0, 64'h0,   32'h0,        64'h0,   0, 0, 0, 32'h13,       64'h0,   0, 0, 0, 1);
        add(1, 64'h200, 32'hffffffff, 64'h20c, 1, 0, 0, 32'h13,       64'h0,   0, 0, 0, 1);
        add(0, 64'h0,   32'h0,        64'h0,   0, 0, 0, 32'h13,       64'h0,   0, 0, 0, 1);

        foreach (vecs[i]) begin
            flush = vecs[i].flush; flush_pc = vecs[i].flush_pc;
            parcel = vecs[i].parcel; parcel_pc = vecs[i].ppc;
            parcel_valid = vecs[i].pv; id_stall = vecs[i].stall;
            step();
            check($sformatf("v%0d_valid", i), if_valid, vecs[i].e_valid);
            check($sformatf("v%0d_instr", i), if_instr, vecs[i].e_instr);
            check($sformatf("v%0d_rvc", i), if_rvc, vecs[i].e_rvc);
            check($sformatf("v%0d_occ", i), if_occupancy, vecs[i].e_occ);
            check($sformatf("v%0d_ready", i), parcel_ready, vecs[i].e_ready);
            if (vecs[i].chk_pc) check($sformatf("v%0d_pc", i), if_pc, vecs[i].e_pc);
        end
        idle_inputs();

        // Fill to full under stall, offer a rejected 5th parcel, then drain; three rounds
        base = 64'h200;
        for (int r = 0; r < 3; r++) begin
            id_stall = 1'b1;
            for (int k = 0; k < 4; k++) begin
                ins = 32'h00100093 + (32'(r * 4 + k) << 20);
                push_parcel(ins, base + 64'(4 * k), 1'b0, 1'b0);
            end
            check($sformatf("full%0d_occ", r), if_occupancy, 8);
            check($sformatf("full%0d_ready", r), parcel_ready, 0);
            push_parcel(32'h00000013, base + 64'h10, 1'b0, 1'b0);
            check($sformatf("full%0d_reject", r), if_occupancy, 8);
            id_stall = 1'b0;
            for (int k = 0; k < 4; k++) begin
                ins = 32'h00100093 + (32'(r * 4 + k) << 20);
                check($sformatf("drain%0d_%0d_valid", r, k), if_valid, 1);
                check($sformatf("drain%0d_%0d_instr", r, k), if_instr, ins);
                check($sformatf("drain%0d_%0d_pc", r, k), if_pc, base + 64'(4 * k));
                step();
            end
            check($sformatf("drain%0d_empty", r), if_occupancy, 0);
            base = base + 64'h10;
        end

        // Fault tagging on a straddling instruction and on lone faulting halfwords
        flush = 1'b1; flush_pc = 64'h200; step(); idle_inputs();
        push_parcel(32'h00930001, 64'h200, 1'b0, 1'b0);
        check("f_rvc_instr", if_instr, 32'h00000001);
        check("f_rvc_pf", if_page_fault, 0);
        step();
        check("f_half_valid", if_valid, 0);
        push_parcel(32'h000000a0, 64'h204, 1'b0, 1'b1);
        check("f_str_valid", if_valid, 1);
        check("f_str_instr", if_instr, 32'h00a00093);
        check("f_str_pc", if_pc, 64'h202);
        check("f_str_pf", if_page_fault, 1);
        check("f_str_mis", if_misaligned, 0);
        step();
        check("f_lone_occ", if_occupancy, 1);
        check("f_lone_valid", if_valid, 1);
        check("f_lone_pf", if_page_fault, 1);
        check("f_lone_rvc", if_rvc, 0);
        check("f_lone_pc", if_pc, 64'h206);
        push_parcel(32'hffffffff, 64'h208, 1'b1, 1'b0);
        check("f_mis_occ", if_occupancy, 2);
        check("f_mis_instr", if_instr, 32'h0000ffff);
        check("f_mis_flag", if_misaligned, 1);
        check("f_mis_pf", if_page_fault, 0);
        step();
        check("f_mis2_valid", if_valid, 1);
        check("f_mis2_pc", if_pc, 64'h20a);
        step();
        check("f_end_valid", if_valid, 0);
        check("f_end_mis", if_misaligned, 0);

        // Reset mid-stream overrides push and flush
        push_parcel(32'h00a00093, 64'h20c, 1'b0, 1'b0);
        rstn = 1'b0; id_stall = 1'b1; flush = 1'b1; flush_pc = 64'h400;
        parcel = 32'h00b00113; parcel_pc = 64'h210; parcel_valid = 1'b1;
        step();
        check("mrst_occ", if_occupancy, 0);
        check("mrst_valid", if_valid, 0);
        check("mrst_pc", if_pc, 64'h200);
        check("mrst_ready", parcel_ready, 1);
        check("mrst_instr", if_instr, 32'h13);
        rstn = 1'b1; idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
